// File: rtl/sweep_gen_pkg.sv
// Shared types and constants for the stepped-frequency sine source.
// Quarter-wave table contents are generated here so the ROM and its users agree on scaling.
package sweep_gen_pkg;

    localparam int LUT_AW_DEF = 8;
    localparam int OUT_W_DEF  = 12;

    localparam logic [1:0] QUAD_0   = 2'd0;
    localparam logic [1:0] QUAD_90  = 2'd1;
    localparam logic [1:0] QUAD_180 = 2'd2;
    localparam logic [1:0] QUAD_270 = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_DWELL,
        ST_STEP,
        ST_DONE
    } sweep_state_t;

    // Entry k of a (2^lut_aw + 1)-entry table spanning 0..pi/2 inclusive, so both 0 and full scale exist.
    function automatic int sine_mag(input int k, input int lut_aw, input int out_w);
        real amp;
        real ang;
        amp = real'((1 << (out_w - 1)) - 1);
        ang = 1.5707963267948966 * real'(k) / real'(1 << lut_aw);
        return $rtoi(amp * $sin(ang) + 0.5);
    endfunction

endpackage

// File: rtl/sweep_stimulus_gen_sine_lut.sv
// Quarter-wave sine ROM with quadrant fold: address mirror in Q1/Q3, negation in Q2/Q3.
// Two registered stages sharing one enable; flush clears both stages synchronously.
module sine_lut_quarter
    import sweep_gen_pkg::*;
#(
    parameter int LUT_AW = LUT_AW_DEF,
    parameter int OUT_W  = OUT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              flush,
    input  logic [LUT_AW+1:0] idx,
    output logic [OUT_W-1:0]  data
);

    localparam int              QTR   = 1 << LUT_AW;
    localparam int              MAG_W = OUT_W - 1;
    localparam logic [LUT_AW:0] QTR_A = {1'b1, {LUT_AW{1'b0}}};

    logic [MAG_W-1:0]  rom [0:QTR];
    logic [1:0]        quad;
    logic [LUT_AW-1:0] addr;
    logic [LUT_AW:0]   raddr;
    logic              neg;
    logic [MAG_W-1:0]  mag_q;
    logic              neg_q;
    logic [OUT_W-1:0]  pos;

    for (genvar k = 0; k <= QTR; k++) begin : g_rom
        assign rom[k] = MAG_W'(sine_mag(k, LUT_AW, OUT_W));
    end

    assign quad = idx[LUT_AW+1:LUT_AW];
    assign addr = idx[LUT_AW-1:0];
    assign pos  = {1'b0, mag_q};

    always_comb begin
        raddr = {1'b0, addr};
        neg   = 1'b0;
        case (quad)
            QUAD_0:   raddr = {1'b0, addr};
            QUAD_90:  raddr = QTR_A - {1'b0, addr};
            QUAD_180: neg   = 1'b1;
            QUAD_270: begin
                raddr = QTR_A - {1'b0, addr};
                neg   = 1'b1;
            end
            default:  raddr = {1'b0, addr};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag_q <= '0;
            neg_q <= 1'b0;
            data  <= '0;
        end else if (flush) begin
            mag_q <= '0;
            neg_q <= 1'b0;
            data  <= '0;
        end else if (en) begin
            mag_q <= rom[raddr];
            neg_q <= neg;
            data  <= neg_q ? -pos : pos;
        end
    end

endmodule

// File: rtl/sweep_stimulus_gen.sv
// Stepped-frequency phase-continuous sine source with settle/dwell per step, valid/ready to the DAC.
// out_valid 3 cycles after start; a stall freezes the whole pipeline, abort flushes it.
module sweep_stimulus_gen
    import sweep_gen_pkg::*;
#(
    parameter int PHASE_W    = 32,
    parameter int LUT_AW     = LUT_AW_DEF,
    parameter int OUT_W      = OUT_W_DEF,
    parameter int SETTLE_CYC = 64,
    parameter int DWELL_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [PHASE_W-1:0] f_start,
    input  logic [PHASE_W-1:0] f_step,
    input  logic [15:0]        n_steps,
    input  logic [DWELL_W-1:0] dwell,
    output logic [OUT_W-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_settle,
    output logic [15:0]        step_idx,
    output logic               step_strobe,
    output logic               busy,
    output logic               done
);

    localparam int               IDX_W    = LUT_AW + 2;
    localparam int               CNT_W    = $clog2(SETTLE_CYC + (1 << DWELL_W)) + 1;
    localparam logic [CNT_W-1:0] SETTLE_N = CNT_W'(SETTLE_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    sweep_state_t       state, state_nxt;
    logic [PHASE_W-1:0] freq, f_step_q, phase;
    logic [15:0]        n_steps_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [CNT_W-1:0]   issue_cnt, xfer_cnt, total;
    logic               en, issue, xfer, last_step;
    logic               s0_vld, s0_settle, s1_vld, s1_settle;
    logic [IDX_W-1:0]   s0_idx;

    assign en        = !out_valid || out_ready;
    assign xfer      = out_valid && out_ready;
    assign total     = SETTLE_N + CNT_W'(dwell_q);
    // Issue is bounded by the per-step sample budget, so the pipeline is empty when the last transfer lands.
    assign issue     = en && (state == ST_SETTLE || state == ST_DWELL) && (issue_cnt < total);
    assign last_step = ({1'b0, step_idx} + 17'd1) >= {1'b0, n_steps_q};

    always_comb begin
        state_nxt   = state;
        busy        = (state != ST_IDLE);
        done        = (state == ST_DONE);
        step_strobe = (state == ST_STEP);
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (start) state_nxt = ST_SETTLE;
                ST_SETTLE: if (xfer && xfer_cnt == SETTLE_N - CNT_ONE) state_nxt = ST_DWELL;
                ST_DWELL:  if (xfer && xfer_cnt == total - CNT_ONE)
                               state_nxt = last_step ? ST_DONE : ST_STEP;
                ST_STEP:   state_nxt = ST_SETTLE;
                ST_DONE:   state_nxt = ST_IDLE;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            freq      <= '0;
            f_step_q  <= '0;
            n_steps_q <= '0;
            dwell_q   <= '0;
            phase     <= '0;
            step_idx  <= '0;
            issue_cnt <= '0;
            xfer_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (abort) begin
                issue_cnt <= '0;
                xfer_cnt  <= '0;
            end else begin
                if (state == ST_IDLE && start) begin
                    freq      <= f_start;
                    f_step_q  <= f_step;
                    n_steps_q <= (n_steps == '0) ? 16'd1 : n_steps;
                    dwell_q   <= (dwell == '0) ? DWELL_W'(1) : dwell;
                    phase     <= '0;
                    step_idx  <= '0;
                    issue_cnt <= '0;
                    xfer_cnt  <= '0;
                end
                if (issue) begin
                    phase     <= phase + freq;
                    issue_cnt <= issue_cnt + CNT_ONE;
                end
                if (xfer) xfer_cnt <= xfer_cnt + CNT_ONE;
                if (state == ST_STEP) begin
                    freq      <= freq + f_step_q;
                    step_idx  <= step_idx + 16'd1;
                    issue_cnt <= '0;
                    xfer_cnt  <= '0;
                end
            end
        end
    end

    // Valid and settle tags ride alongside the LUT stages so they stay aligned with out_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_vld     <= 1'b0;
            s0_settle  <= 1'b0;
            s0_idx     <= '0;
            s1_vld     <= 1'b0;
            s1_settle  <= 1'b0;
            out_valid  <= 1'b0;
            out_settle <= 1'b0;
        end else if (abort) begin
            s0_vld     <= 1'b0;
            s0_settle  <= 1'b0;
            s0_idx     <= '0;
            s1_vld     <= 1'b0;
            s1_settle  <= 1'b0;
            out_valid  <= 1'b0;
            out_settle <= 1'b0;
        end else if (en) begin
            s0_vld     <= issue;
            s0_settle  <= issue && (issue_cnt < SETTLE_N);
            if (issue) s0_idx <= phase[PHASE_W-1 -: IDX_W];
            s1_vld     <= s0_vld;
            s1_settle  <= s0_settle;
            out_valid  <= s1_vld;
            out_settle <= s1_settle;
        end
    end

    sine_lut_quarter #(
        .LUT_AW (LUT_AW),
        .OUT_W  (OUT_W)
    ) u_lut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .flush (abort),
        .idx   (s0_idx),
        .data  (out_data)
    );

endmodule

// File: tb/tb_sweep_stimulus_gen.sv
// Bench for sweep_stimulus_gen: reference sweep model feeds a scoreboard, a negedge monitor checks transfers.
module tb_sweep_stimulus_gen;

    localparam int SETTLE = 64;
    localparam int BUDGET = 20000;

    logic        clk = 1'b0;
    logic        rst_n, start, abort, out_ready;
    logic [31:0] f_start, f_step;
    logic [15:0] n_steps, dwell;
    logic [11:0] out_data;
    logic        out_valid, out_settle, step_strobe, busy, done;
    logic [15:0] step_idx;

    typedef struct {
        logic [11:0] data;
        logic        settle;
        logic [15:0] step;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          strobe_cnt = 0;
    int          done_cnt = 0;
    int          ready_duty = 100;
    bit          pst = 1'b0;
    bit          pab = 1'b0;
    logic [11:0] hd = '0;
    logic        hs = 1'b0;

    sweep_stimulus_gen dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .f_start     (f_start),
        .f_step      (f_step),
        .n_steps     (n_steps),
        .dwell       (dwell),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_settle  (out_settle),
        .step_idx    (step_idx),
        .step_strobe (step_strobe),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint got, input longint req);
        n_checks++;
        if (got != req) begin
            n_errors++;
            $display("FAIL %s: got %0d, required %0d", nm, got, req);
        end
    endtask

    function automatic longint outvec();
        return {31'd0, out_valid, out_data, out_settle, step_idx, step_strobe, busy, done};
    endfunction

    // Ideal full-scale sine of a 10-bit phase index, rounded symmetrically.
    function automatic logic [11:0] sine_ref(input logic [9:0] pidx);
        real x;
        int  v;
        x = 2047.0 * $sin(6.283185307179586 * real'(pidx) / 1024.0);
        v = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
        return 12'(v);
    endfunction

    task automatic model_push(input logic [31:0] fs, input logic [31:0] fst,
                              input logic [15:0] ns, input logic [15:0] dw);
        logic [31:0] ph, fr;
        int          neff, deff;
        exp_t        e;
        ph   = '0;
        fr   = fs;
        neff = (ns == 0) ? 1 : int'(ns);
        deff = (dw == 0) ? 1 : int'(dw);
        for (int s = 0; s < neff; s++) begin
            for (int k = 0; k < SETTLE + deff; k++) begin
                e.data   = sine_ref(ph[31:22]);
                e.settle = (k < SETTLE);
                e.step   = 16'(s);
                sb.push_back(e);
                ph = ph + fr;
            end
            fr = fr + fst;
        end
    endtask

    task automatic do_abort();
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
    endtask

    task automatic run_sweep(input string nm, input logic [31:0] fs, input logic [31:0] fst,
                             input logic [15:0] ns, input logic [15:0] dw, input int duty,
                             input bit poke, input bit chk_lat);
        int bd, bs, lat, neff;
        bit ok;
        neff       = (ns == 0) ? 1 : int'(ns);
        ready_duty = duty;
        model_push(fs, fst, ns, dw);
        f_start = fs;
        f_step  = fst;
        n_steps = ns;
        dwell   = dw;
        bd      = done_cnt;
        bs      = strobe_cnt;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        if (chk_lat) begin
            lat = 0;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                if (out_valid) break;
                @(posedge clk);
                lat++;
            end
            chk({nm, "_latency"}, lat, 3);
        end
        if (poke) begin
            repeat (20) @(posedge clk);
            #1 f_start = $urandom;
            f_step  = $urandom;
            n_steps = 16'd9;
            dwell   = 16'd3;
            start   = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        ok = 1'b0;
        for (int c = 0; c < BUDGET; c++) begin
            @(negedge clk);
            if (done_cnt != bd) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: no done pulse within %0d cycles, required one", nm, BUDGET);
            do_abort();
            sb.delete();
        end
        repeat (3) @(negedge clk);
        chk({nm, "_done_pulses"}, done_cnt - bd, 1);
        chk({nm, "_strobes"}, strobe_cnt - bs, neff - 1);
        chk({nm, "_busy_after"}, busy, 0);
        chk({nm, "_samples_left"}, sb.size(), 0);
    endtask

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1 out_ready = ($urandom_range(0, 99) < ready_duty);
        end
    end

    // Monitor: scoreboard pops on transfers, stall stability, strobe/done counting.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (pst && !pab) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, hd);
                chk("stall_settle", out_settle, hs);
            end
            pst = out_valid && !out_ready;
            pab = abort;
            hd  = out_data;
            hs  = out_settle;
            if (step_strobe) strobe_cnt++;
            if (done) done_cnt++;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_sample: got data %0d with nothing expected, required no transfer",
                             out_data);
                end else begin
                    e = sb.pop_front();
                    chk("sample_data", out_data, e.data);
                    chk("sample_settle", out_settle, e.settle);
                    chk("sample_step_idx", step_idx, e.step);
                end
            end
        end
    end

    initial begin
        bit found;
        int bd;
        rst_n   = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        f_start = '0;
        f_step  = '0;
        n_steps = '0;
        dwell   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", outvec(), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_outputs", outvec(), 0);
        end

        @(posedge clk); #1 abort = 1'b1;
        start = 1'b1;
        f_start = 32'h1234_5678;
        @(posedge clk); #1 abort = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_beats_start_busy", busy, 0);
        end

        run_sweep("single", 32'h4000_0000, 32'h0, 16'd1, 16'd8, 100, 1'b0, 1'b1);
        run_sweep("multi", 32'h0400_0000, 32'h1000_0000, 16'd3, 16'd4, 100, 1'b1, 1'b0);
        for (int r = 0; r < 3; r++)
            run_sweep("rand", $urandom, $urandom, 16'($urandom_range(1, 3)),
                      16'($urandom_range(1, 12)), 30, 1'b0, 1'b0);

        ready_duty = 100;
        model_push(32'h0400_0000, 32'h0100_0000, 16'd2, 16'd16);
        f_start = 32'h0400_0000;
        f_step  = 32'h0100_0000;
        n_steps = 16'd2;
        dwell   = 16'd16;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (out_valid && !out_settle) begin
                found = 1'b1;
                break;
            end
        end
        chk("abort_reached_dwell", found, 1);
        ready_duty = 0;
        repeat (3) @(negedge clk);
        chk("abort_pre_valid", out_valid, 1);
        chk("abort_pre_ready", out_ready, 0);
        chk("abort_pre_busy", busy, 1);
        bd = done_cnt;
        do_abort();
        @(negedge clk);
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        repeat (5) @(negedge clk);
        chk("abort_no_done", done_cnt, bd);
        sb.delete();

        run_sweep("after_abort", 32'h0880_0000, 32'h0200_0000, 16'd2, 16'd5, 70, 1'b0, 1'b0);
        run_sweep("zero_cfg", 32'hFFFF_FFFF, 32'd2, 16'd0, 16'd0, 100, 1'b0, 1'b0);
        run_sweep("wrap", 32'hFFFF_FFFF, 32'd2, 16'd2, 16'd0, 100, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
